sum_serial_tx: RTL and testbench



---
 rtl/sum_serial_tx_pkg.sv | 33 +++
 rtl/sum_serial_tx_if.sv | 38 +++
 rtl/sum_serial_tx_bit_timer.sv | 45 ++++
 rtl/sum_serial_tx.sv | 177 +++++++++++++++++
 tb/tb_sum_serial_tx.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// sum_tx_pkg
// Shared types and helpers for the sum_serial_tx transmitter.
//   tx_state_e    : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   frame_cycles  : enabled clock cycles in one frame, start bit through stop bit
//   bit_idx_width : width of the data-bit index that counts 0..WIDTH
//   BIT_IDX_W     : bit-index width for the default 8-bit operand width
// -----------------------------------------------------------------------------
package sum_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int BIT_IDX_W        = $clog2(DEF_WIDTH + 1);

  // A frame holds one start bit, WIDTH+1 data bits, one parity bit and one stop bit.
  function automatic int frame_cycles(input int width, input int clks_per_bit);
    return (width + 4) * clks_per_bit;
  endfunction

  // The data index must be able to hold the value WIDTH, which is the carry bit.
  function automatic int bit_idx_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sum_serial_tx_if.sv
// -----------------------------------------------------------------------------
// sum_serial_tx_if
// Request/serial-line bundle of the sum transmitter.
//   ena     : clock enable; low freezes the transmitter
//   op_a    : operand A, sampled when a start is accepted
//   op_b    : operand B, sampled when a start is accepted
//   start   : request one frame
//   ready   : transmitter idle; a start is accepted only while high
//   tx_out  : serial line, idles high
//   tx_busy : a frame is in flight
//   done    : one-cycle pulse when a frame completes
// The master modport drives the request side. The slave modport is the
// transmitter.
// -----------------------------------------------------------------------------
interface sum_serial_tx_if #(
  parameter int WIDTH = 8
);

  logic             ena;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             start;
  logic             ready;
  logic             tx_out;
  logic             tx_busy;
  logic             done;

  modport master (
    output ena, op_a, op_b, start,
    input  ready, tx_out, tx_busy, done
  );

  modport slave (
    input  ena, op_a, op_b, start,
    output ready, tx_out, tx_busy, done
  );

endinterface

// File: rtl/sum_serial_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// sum_tx_bit_timer
// Serial bit timer. It counts enabled cycles 0..CLKS_PER_BIT-1 and flags the
// terminal count.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   ena   : clock enable; the count holds while low
//   clear : restart the count at 0 (frame acceptance)
//   tick  : high in the enabled cycle that ends a serial bit
// -----------------------------------------------------------------------------
module sum_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clear,
  output logic tick
);

  // A one-cycle bit still needs a 1-bit counter. It stays at 0, so every enabled cycle ticks.
  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // A clear has priority over the tick. A clear arrives only in IDLE, where ticks are ignored.
  assign tick = ena & ~clear & (r_cnt == LAST);

  // Cycle counter: restart on clear or at terminal count, hold while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (ena) begin
      if (clear || (r_cnt == LAST)) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/sum_serial_tx.sv
// -----------------------------------------------------------------------------
// sum_serial_tx
// Captures two operands on start and forms their (WIDTH+1)-bit sum, including
// the carry. It sends the sum LSB-first as a UART-style frame: a start bit (0),
// WIDTH+1 data bits, an even-parity bit and a stop bit (1). Each bit lasts
// CLKS_PER_BIT enabled cycles.
//   clk   : system clock
//   rst_n : asynchronous active-low reset; the line returns high at once
//   bus   : sum_serial_tx_if slave (ena, op_a, op_b, start -> ready, tx_out,
//           tx_busy, done); every output comes straight from a flop
// -----------------------------------------------------------------------------
module sum_serial_tx
  import sum_tx_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           rst_n,
  sum_serial_tx_if.slave bus
);

  localparam int IDX_W = bit_idx_width(WIDTH);

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [WIDTH:0] v);
    return ^v;
  endfunction

  tx_state_e        r_state, w_state_nxt;
  logic [WIDTH:0]   r_shreg, w_shreg_nxt;
  logic             r_par, w_par_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [WIDTH:0]   w_sum;
  logic             w_accept;
  logic             w_tick;

  // Zero-extend both operands so the carry lands in bit WIDTH.
  assign w_sum    = {1'b0, bus.op_a} + {1'b0, bus.op_b};
  assign w_accept = bus.ena & bus.start & (r_state == IDLE);

  sum_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (bus.ena),
    .clear (w_accept),
    .tick  (w_tick)
  );

  // Next-state and next-output logic. Every registered output is computed one
  // cycle ahead, so each line level changes on the same edge as its state.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_par_nxt   = r_par;
    w_idx_nxt   = r_idx;
    w_tx_nxt    = r_tx;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;

    if (bus.ena) begin
      case (r_state)
        IDLE: begin
          w_done_nxt = 1'b0;
          if (w_accept) begin
            w_state_nxt = START;
            w_shreg_nxt = w_sum;
            w_par_nxt   = even_parity(w_sum);
            w_idx_nxt   = {IDX_W{1'b0}};
            w_tx_nxt    = 1'b0;
            w_ready_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
          end else begin
            w_tx_nxt    = 1'b1;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end
        end

        START: begin
          if (w_tick) begin
            // Bit 0 goes onto the line now. The register shifts so bit 1 is next at [0].
            w_state_nxt = DATA;
            w_tx_nxt    = r_shreg[0];
            w_shreg_nxt = {1'b0, r_shreg[WIDTH:1]};
          end else begin
            w_tx_nxt    = 1'b0;
          end
        end

        DATA: begin
          if (w_tick) begin
            if (r_idx == IDX_W'(WIDTH)) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_tx_nxt    = r_shreg[0];
              w_shreg_nxt = {1'b0, r_shreg[WIDTH:1]};
            end
          end else begin
            w_tx_nxt    = r_tx;
          end
        end

        PARITY: begin
          if (w_tick) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_tx_nxt    = r_par;
          end
        end

        STOP: begin
          if (w_tick) begin
            // The done cycle is also a normal IDLE cycle, so a back-to-back start is accepted in it.
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_tx_nxt    = 1'b1;
          end
        end

        default: begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b0;
        end
      endcase
    end else begin
      // Disabled cycle: every register keeps the value it was given by default.
      w_state_nxt = r_state;
    end
  end

  // State, datapath and output registers. Reset forces the line idle-high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= {(WIDTH+1){1'b0}};
      r_par   <= 1'b0;
      r_idx   <= {IDX_W{1'b0}};
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_par   <= w_par_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.tx_out  = r_tx;
  assign bus.ready   = r_ready;
  assign bus.tx_busy = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_sum_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_sum_serial_tx
// Bench for sum_serial_tx. u_dut4 runs with 4 clocks per bit and u_dut1 with
// 1 clock per bit. Each start pushes the expected sum onto a scoreboard. The
// collector records the line while tx_busy is high, pops the entry and checks
// the frame against the bit sequence rebuilt from that sum.
// -----------------------------------------------------------------------------
module tb_sum_serial_tx;
  import sum_tx_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W:0] sum;
    int         cpb;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  sum_serial_tx_if #(.WIDTH(W)) bus4();
  sum_serial_tx_if #(.WIDTH(W)) bus1();

  sum_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  sum_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? bus4.tx_out : bus1.tx_out;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus4.tx_busy : bus1.tx_busy;
  endfunction
  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus4.ready : bus1.ready;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus4.done : bus1.done;
  endfunction
  function automatic int cpb_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  task automatic set_start(input int sel, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (sel == 0) begin
      bus4.start = v; bus4.op_a = a; bus4.op_b = b;
    end else begin
      bus1.start = v; bus1.op_a = a; bus1.op_b = b;
    end
  endtask

  task automatic set_ena(input int sel, input logic v);
    if (sel == 0) bus4.ena = v;
    else          bus1.ena = v;
  endtask

  // Raise start with the operands and push the expected sum onto the scoreboard.
  task automatic begin_frame(input int sel, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    set_start(sel, 1'b1, a, b);
    e.sum = {1'b0, a} + {1'b0, b};
    e.cpb = cpb_of(sel);
    sb.push_back(e);
  endtask

  // Scoreboard collector. It records one frame, can drop ena or inject a start
  // at chosen sample indices, and can chain the next start into the done cycle.
  task automatic collect_frame(input int sel, input int hold_at, input int hold_len, input int inj_at,
                               input bit chain, input logic [W-1:0] ca, input logic [W-1:0] cb);
    logic cap[$];
    logic exp_q[$];
    exp_t e;
    int   guard      = 0;
    int   first_busy = -1;
    int   idx;
    int   bad_at     = -1;
    int   exp_len;
    bit   ready_bad  = 1'b0;
    bit   ended      = 1'b0;
    while (!ended && guard < 400) begin
      @(negedge clk);
      guard++;
      if (get_busy(sel) === 1'b1) begin
        if (first_busy < 0) first_busy = guard;
        cap.push_back(get_tx(sel));
        if (get_ready(sel) !== 1'b0) ready_bad = 1'b1;
        idx = cap.size() - 1;
        if (idx == inj_at) set_start(sel, 1'b1, 8'h12, 8'h34);
        else               set_start(sel, 1'b0, 8'($urandom), 8'($urandom));
        if (idx == hold_at)            set_ena(sel, 1'b0);
        if (idx == hold_at + hold_len) set_ena(sel, 1'b1);
      end else if (cap.size() > 0) begin
        ended = 1'b1;
        n_tests++;
        if (get_done(sel) !== 1'b1 || get_ready(sel) !== 1'b1 || get_tx(sel) !== 1'b1) begin
          n_fail++;
          $display("FAIL done_cycle sel=%0d: done=%b ready=%b tx=%b, required 1 1 1",
                   sel, get_done(sel), get_ready(sel), get_tx(sel));
        end
        if (chain) begin_frame(sel, ca, cb);
      end else begin
        set_start(sel, 1'b0, 8'($urandom), 8'($urandom));
      end
    end
    n_tests++;
    if (!ended) begin
      n_fail++;
      $display("FAIL frame_timeout sel=%0d: frame not finished after %0d cycles, required finish", sel, guard);
      set_ena(sel, 1'b1);
      set_start(sel, 1'b0, 8'h00, 8'h00);
      return;
    end
    n_tests++;
    if (first_busy !== 1) begin
      n_fail++;
      $display("FAIL start_latency sel=%0d: busy first seen %0d cycles after start, required 1", sel, first_busy);
    end
    n_tests++;
    if (ready_bad) begin
      n_fail++;
      $display("FAIL ready_during_frame sel=%0d: ready was 1 while busy, required 0", sel);
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty sel=%0d: frame observed with no expected entry", sel);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < W + 4; k++) begin
      logic bv;
      if (k == 0)          bv = 1'b0;
      else if (k <= W + 1) bv = e.sum[k-1];
      else if (k == W + 2) bv = ^e.sum;
      else                 bv = 1'b1;
      for (int c = 0; c < e.cpb; c++) exp_q.push_back(bv);
    end
    for (int h = 0; h < hold_len; h++) exp_q.insert(hold_at + 1, exp_q[hold_at]);
    exp_len = frame_cycles(W, e.cpb) + hold_len;
    n_tests++;
    if (cap.size() != exp_len || exp_q.size() != exp_len) begin
      n_fail++;
      $display("FAIL frame_length sel=%0d: got %0d cycles, required %0d", sel, cap.size(), exp_len);
    end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      if (bad_at < 0 && cap[i] !== exp_q[i]) bad_at = i;
    end
    n_tests++;
    if (bad_at >= 0) begin
      n_fail++;
      $display("FAIL frame_bits sel=%0d sum=%03h: cycle %0d line=%b, required %b",
               sel, e.sum, bad_at, cap[bad_at], exp_q[bad_at]);
    end
    if (!chain) begin
      @(negedge clk);
      n_tests++;
      if (get_done(sel) !== 1'b0 || get_ready(sel) !== 1'b1) begin
        n_fail++;
        $display("FAIL done_pulse_width sel=%0d: done=%b ready=%b one cycle later, required 0 1",
                 sel, get_done(sel), get_ready(sel));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.ena = 1'b1; bus1.ena = 1'b1;
    set_start(0, 1'b0, 8'h00, 8'h00);
    set_start(1, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus4.tx_out, bus4.ready, bus4.tx_busy, bus4.done} !== 4'b1100 ||
        {bus1.tx_out, bus1.ready, bus1.tx_busy, bus1.done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_state: tx/ready/busy/done = %b%b%b%b and %b%b%b%b, required 1100",
               bus4.tx_out, bus4.ready, bus4.tx_busy, bus4.done,
               bus1.tx_out, bus1.ready, bus1.tx_busy, bus1.done);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus4.tx_out, bus4.ready, bus4.tx_busy, bus4.done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL idle_after_reset: tx/ready/busy/done = %b%b%b%b, required 1100",
               bus4.tx_out, bus4.ready, bus4.tx_busy, bus4.done);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    begin_frame(0, 8'h7F, 8'h01);
    collect_frame(0, -1, 0, -1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_carry();
    @(negedge clk);
    begin_frame(0, 8'hFF, 8'h01);
    collect_frame(0, -1, 0, -1, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    begin_frame(0, 8'hFF, 8'hFF);
    collect_frame(0, -1, 0, -1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    begin_frame(0, 8'h00, 8'h00);
    collect_frame(0, -1, 0, -1, 1'b1, 8'h55, 8'hAA);
    collect_frame(0, -1, 0, -1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_busy_reject();
    int bad = 0;
    @(negedge clk);
    begin_frame(0, 8'h33, 8'h44);
    collect_frame(0, -1, 0, 20, 1'b0, 8'h00, 8'h00);
    repeat (8) begin
      @(negedge clk);
      if (bus4.tx_busy !== 1'b0 || bus4.tx_out !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_reject_no_second_frame: %0d cycles busy or low after done, required 0", bad);
    end
  endtask

  task automatic test_ena_gating();
    @(negedge clk);
    begin_frame(0, 8'h3C, 8'h0A);
    collect_frame(0, 41, 7, -1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    int guard = 0;
    int n     = 0;
    int bad   = 0;
    @(negedge clk);
    begin_frame(0, 8'h0F, 8'h03);
    while (n < 18 && guard < 100) begin
      @(negedge clk);
      guard++;
      set_start(0, 1'b0, 8'h00, 8'h00);
      if (bus4.tx_busy === 1'b1) n++;
    end
    n_tests++;
    if (n < 18) begin
      n_fail++;
      $display("FAIL reset_mid_setup: only %0d busy cycles seen, required 18", n);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus4.tx_out, bus4.ready, bus4.tx_busy, bus4.done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_mid_frame_async: tx/ready/busy/done = %b%b%b%b, required 1100",
               bus4.tx_out, bus4.ready, bus4.tx_busy, bus4.done);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus4.tx_busy !== 1'b0 || bus4.tx_out !== 1'b1 || bus4.ready !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_no_resume: %0d non-idle cycles after release, required 0", bad);
    end
  endtask

  task automatic test_cpb1();
    @(negedge clk);
    begin_frame(1, 8'h7F, 8'h01);
    collect_frame(1, -1, 0, -1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      begin_frame(0, 8'($urandom), 8'($urandom));
      collect_frame(0, -1, 0, -1, 1'b0, 8'h00, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_busy_reject();
    test_ena_gating();
    test_reset_mid_frame();
    test_cpb1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
